// File: rtl/rx_seq_ctrl.sv
// rtl/rx_seq_ctrl.sv - UART receive sequencer: start validation, shift strobes, stop check, buffer load
module rx_seq_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  input  logic new_packet_detected,
  input  logic framing_error,
  output logic shift_strobe,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic load_buffer,
  output logic false_start,
  output logic busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 2);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] STOP_IDX  = BW'(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    RECEIVE   = 3'd2,
    STOP_CHK  = 3'd3,
    ERR_WAIT  = 3'd4,
    LOAD      = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitcnt;

  // Outputs are decided on the transition so each pulse lines up with the
  // state/count value it belongs to (strobe coincides with cnt == last).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bitcnt       <= '0;
      shift_strobe <= 1'b0;
      sbc_clear    <= 1'b0;
      sbc_enable   <= 1'b0;
      load_buffer  <= 1'b0;
      false_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      shift_strobe <= 1'b0;
      sbc_clear    <= 1'b0;
      sbc_enable   <= 1'b0;
      load_buffer  <= 1'b0;
      false_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (new_packet_detected) begin
            state     <= START_CHK;
            cnt       <= '0;
            sbc_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START_CHK: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (sync_in) begin
              state       <= IDLE;
              false_start <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state  <= RECEIVE;
              bitcnt <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RECEIVE: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bitcnt == STOP_IDX) begin
              state      <= STOP_CHK;
              sbc_enable <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == PRE_LAST) begin
              shift_strobe <= 1'b1;
              bitcnt       <= bitcnt + BW'(1);
            end
          end
        end
        STOP_CHK: state <= ERR_WAIT;
        ERR_WAIT: begin
          if (framing_error) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state       <= LOAD;
            load_buffer <= 1'b1;
          end
        end
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
